// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the tile-grid pixel generator:
//   - RGB111 colour constants
//   - clog2 constant function (minimum result 1 so derived widths are never 0)
//   - tile geometry for the default 640x480 / 4x2 configuration
// Modules that need geometry for other parameter sets derive it locally
// from their own parameters.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam int SCREEN_X_DEF = 640;
    localparam int SCREEN_Y_DEF = 480;
    localparam int COLS_DEF     = 4;
    localparam int ROWS_DEF     = 2;

    localparam int TILE_W = SCREEN_X_DEF / COLS_DEF;
    localparam int TILE_H = SCREEN_Y_DEF / ROWS_DEF;

    // Ceiling log2, clamped to at least 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tile_locator.sv
// ---------------------------------------------------------------------------
// tile_locator
// Stage 1 of the pixel pipeline: maps a driver position to tile column/row
// and flags border/remainder pixels and visibility. Column and row come from
// a comparator chain against constant tile boundaries, so no divider exists.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   pos_x_i/pos_y_i driver next-pixel position
//   col_o/row_o     tile column/row (registered)
//   on_edge_o       border or remainder pixel (registered)
//   visible_o       position inside SCREEN_X x SCREEN_Y (registered)
//   vld_o           stage output holds a real sample (low right after reset)
// ---------------------------------------------------------------------------
module tile_locator
    import vga_pkg::clog2;
#(
    parameter int SCREEN_X = 640,
    parameter int SCREEN_Y = 480,
    parameter int COLS     = 4,
    parameter int ROWS     = 2,
    parameter int BORDER   = 1,
    localparam int CW      = clog2(COLS),
    localparam int RW      = clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pos_x_i,
    input  logic [8:0]    pos_y_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          on_edge_o,
    output logic          visible_o,
    output logic          vld_o
);

    localparam int TILE_W = SCREEN_X / COLS;
    localparam int TILE_H = SCREEN_Y / ROWS;

    int px;
    int py;
    int base_x;
    int base_y;
    int off_x;
    int off_y;
    logic edge_x;
    logic edge_y;

    logic [CW-1:0] col_d,  col_q;
    logic [RW-1:0] row_d,  row_q;
    logic          edge_d, edge_q;
    logic          vis_d,  vis_q;
    logic          vld_q;

    always_comb begin
        px     = int'(pos_x_i);
        py     = int'(pos_y_i);
        col_d  = '0;
        row_d  = '0;
        base_x = 0;
        base_y = 0;
        // Last boundary passed wins; remainder pixels land in the last tile
        // but are flagged as edge below, so their index is never used.
        for (int k = 1; k < COLS; k++) begin
            if (px >= k * TILE_W) begin
                col_d  = CW'(k);
                base_x = k * TILE_W;
            end
        end
        for (int k = 1; k < ROWS; k++) begin
            if (py >= k * TILE_H) begin
                row_d  = RW'(k);
                base_y = k * TILE_H;
            end
        end
        off_x  = px - base_x;
        off_y  = py - base_y;
        edge_x = (off_x < BORDER) || (off_x >= TILE_W - BORDER) || (px >= COLS * TILE_W);
        edge_y = (off_y < BORDER) || (off_y >= TILE_H - BORDER) || (py >= ROWS * TILE_H);
        edge_d = edge_x || edge_y;
        vis_d  = (px < SCREEN_X) && (py < SCREEN_Y);
    end

    // ---- stage 1 register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            edge_q <= 1'b0;
            vis_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            edge_q <= edge_d;
            vis_q  <= vis_d;
            vld_q  <= 1'b1;
        end
    end

    assign col_o     = col_q;
    assign row_o     = row_q;
    assign on_edge_o = edge_q;
    assign visible_o = vis_q;
    assign vld_o     = vld_q;

endmodule

// File: rtl/vga_tile_grid.sv
// ---------------------------------------------------------------------------
// vga_tile_grid
// Tile-grid pixel generator for the 640x480 VGA driver. Returns the colour
// of the driver's next-pixel position two clocks later.
//   - shadow colour file written by the game logic, copied wholesale into
//     the active file on frame_start (rendering only reads active)
//   - borders/remainder pixels in BORDER_COLOR, off-screen in OUT_COLOR
//   - optional blinking (colour-inverted) cursor on one tile
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   pos_x, pos_y         driver next-pixel position
//   frame_start          one-cycle pulse per frame
//   wr_en/wr_addr/wr_data shadow file write (out-of-range addresses ignored)
//   cursor_en/cursor_addr cursor enable and tile
//   pixel_out            colour, 2 cycles after pos
//   pixel_tile           tile index of pixel_out (0 on border/outside)
//   blink_phase          1 while the cursor tile is shown inverted
// ---------------------------------------------------------------------------
module vga_tile_grid
    import vga_pkg::clog2;
#(
    parameter int            SCREEN_X     = 640,
    parameter int            SCREEN_Y     = 480,
    parameter int            COLS         = 4,
    parameter int            ROWS         = 2,
    parameter int            DW           = 3,
    parameter int            BORDER       = 1,
    parameter logic [DW-1:0] BORDER_COLOR = DW'(3'b100),
    parameter logic [DW-1:0] OUT_COLOR    = DW'(3'b111),
    parameter int            BLINK_FRAMES = 30,
    localparam int           TW           = clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pos_x,
    input  logic [8:0]    pos_y,
    input  logic          frame_start,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          cursor_en,
    input  logic [TW-1:0] cursor_addr,
    output logic [DW-1:0] pixel_out,
    output logic [TW-1:0] pixel_tile,
    output logic          blink_phase
);

    localparam int NT  = COLS * ROWS;
    localparam int CW  = clog2(COLS);
    localparam int RW  = clog2(ROWS);
    localparam int BCW = clog2(BLINK_FRAMES);

    logic [DW-1:0] shadow_q [NT];
    logic [DW-1:0] shadow_d [NT];
    logic [DW-1:0] active_q [NT];
    logic [DW-1:0] active_d [NT];

    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_q,     blink_d;

    logic [CW-1:0] col_p1;
    logic [RW-1:0] row_p1;
    logic          edge_p1;
    logic          vis_p1;
    logic          vld_p1;
    logic [TW-1:0] idx_p1;

    logic [DW-1:0] pix_p2_d,  pix_p2_q;
    logic [TW-1:0] tile_p2_d, tile_p2_q;

    // Colour files: the swap reads shadow_q, i.e. the pre-edge contents, so a
    // write landing in the same cycle as frame_start waits for the next swap.
    always_comb begin
        shadow_d = shadow_q;
        active_d = frame_start ? shadow_q : active_q;
        if (wr_en && (int'(wr_addr) < NT)) begin
            shadow_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // ---- stage 1: geometry ----
    tile_locator #(
        .SCREEN_X (SCREEN_X),
        .SCREEN_Y (SCREEN_Y),
        .COLS     (COLS),
        .ROWS     (ROWS),
        .BORDER   (BORDER)
    ) u_locator (
        .clk       (clk),
        .rst       (rst),
        .pos_x_i   (pos_x),
        .pos_y_i   (pos_y),
        .col_o     (col_p1),
        .row_o     (row_p1),
        .on_edge_o (edge_p1),
        .visible_o (vis_p1),
        .vld_o     (vld_p1)
    );

    assign idx_p1 = TW'(int'(row_p1) * COLS + int'(col_p1));

    // ---- stage 2: colour selection ----
    always_comb begin
        pix_p2_d  = '0;
        tile_p2_d = '0;
        if (!vld_p1) begin
            // Pipeline still refilling after reset: hold black.
            pix_p2_d = '0;
        end else if (!vis_p1) begin
            pix_p2_d = OUT_COLOR;
        end else if (edge_p1) begin
            pix_p2_d = BORDER_COLOR;
        end else begin
            tile_p2_d = idx_p1;
            pix_p2_d  = active_q[idx_p1];
            if (cursor_en && (cursor_addr == idx_p1) && blink_q) begin
                pix_p2_d = ~active_q[idx_p1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_p2_q  <= '0;
            tile_p2_q <= '0;
        end else begin
            pix_p2_q  <= pix_p2_d;
            tile_p2_q <= tile_p2_d;
        end
    end

    assign pixel_out   = pix_p2_q;
    assign pixel_tile  = tile_p2_q;
    assign blink_phase = blink_q;

endmodule

// File: tb/tb_vga_tile_grid.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_grid
// Two instances (4x2 default and 3x3) share stimulus. A behavioural model
// computes each pixel from the tile rules with division/modulo and tracks
// shadow/active files and the blink counter as plain arrays.
// ---------------------------------------------------------------------------
module tb_vga_tile_grid;

    localparam int SX = 640;
    localparam int SY = 480;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       frame_start;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [3:0] wr_addr_b;
    logic [2:0] wr_data;
    logic       cursor_en;
    logic [2:0] cur_a;
    logic [3:0] cur_b;
    logic [2:0] pix_a, pix_b;
    logic [2:0] tile_a;
    logic [3:0] tile_b;
    logic       ph_a, ph_b;

    always #20 clk = ~clk;

    vga_tile_grid #(.COLS(4), .ROWS(2)) dut_a (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr_a),
        .wr_data(wr_data), .cursor_en(cursor_en), .cursor_addr(cur_a),
        .pixel_out(pix_a), .pixel_tile(tile_a), .blink_phase(ph_a)
    );

    vga_tile_grid #(.COLS(3), .ROWS(3)) dut_b (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr_b),
        .wr_data(wr_data), .cursor_en(cursor_en), .cursor_addr(cur_b),
        .pixel_out(pix_b), .pixel_tile(tile_b), .blink_phase(ph_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int expv);
        checks++;
        if (act !== 32'(expv)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cols [2] = '{4, 3};
    int rows [2] = '{2, 3};
    int sh [2][16];
    int ac [2][16];
    int cnt, phase;
    int mx, my, mv;
    int ex_pix [2];
    int ex_tile [2];

    function automatic void model_px(input int inst, input int x, input int y,
                                     input int cen, input int caddr,
                                     output int pix, output int tile);
        int tw, th, idx;
        tw   = SX / cols[inst];
        th   = SY / rows[inst];
        tile = 0;
        if (x >= SX || y >= SY) begin
            pix = 7;
        end else if (x >= cols[inst] * tw || y >= rows[inst] * th ||
                     (x % tw) < 1 || (x % tw) >= tw - 1 ||
                     (y % th) < 1 || (y % th) >= th - 1) begin
            pix = 4;
        end else begin
            idx  = (y / th) * cols[inst] + (x / tw);
            pix  = ac[inst][idx];
            if (cen != 0 && caddr == idx && phase != 0) pix = (~pix) & 7;
            tile = idx;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 16; j++) begin
                    sh[i][j] = 0;
                    ac[i][j] = 0;
                end
                ex_pix[i]  = 0;
                ex_tile[i] = 0;
            end
            cnt = 0; phase = 0; mv = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mv == 0) begin
                    ex_pix[i]  = 0;
                    ex_tile[i] = 0;
                end else begin
                    model_px(i, mx, my, int'(cursor_en),
                             (i == 0) ? int'(cur_a) : int'(cur_b),
                             ex_pix[i], ex_tile[i]);
                end
            end
            mx = int'(pos_x); my = int'(pos_y); mv = 1;
            if (frame_start) begin
                ac = sh;
                if (cnt == 29) begin cnt = 0; phase = 1 - phase; end
                else cnt = cnt + 1;
            end
            if (wr_en) begin
                sh[0][wr_addr_a] = int'(wr_data);
                if (wr_addr_b < 4'd9) sh[1][wr_addr_b] = int'(wr_data);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("pix_a",   pix_a,  ex_pix[0]);
        chk("tile_a",  tile_a, ex_tile[0]);
        chk("pix_b",   pix_b,  ex_pix[1]);
        chk("tile_b",  tile_b, ex_tile[1]);
        chk("phase_a", ph_a,   phase);
        chk("phase_b", ph_b,   phase);
    end

    // ---------------- stimulus helpers ----------------
    task automatic show(input int x, input int y);
        @(negedge clk);
        pos_x = 10'(x); pos_y = 9'(y);
        frame_start = 1'b0; wr_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic fs();
        @(negedge clk); frame_start = 1'b1; wr_en = 1'b0;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic wr(input int a, input int b, input int d, input bit with_fs);
        @(negedge clk);
        wr_en = 1'b1; wr_addr_a = 3'(a); wr_addr_b = 4'(b); wr_data = 3'(d);
        frame_start = with_fs;
        @(negedge clk);
        wr_en = 1'b0; frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_pix_a", pix_a, 0);
        chk("rst_async_pix_b", pix_b, 0);
        chk("rst_async_tile_a", tile_a, 0);
        chk("rst_async_phase", ph_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1; pos_x = 10'd10; pos_y = 9'd10;
        frame_start = 0; wr_en = 0; wr_addr_a = 0; wr_addr_b = 0; wr_data = 0;
        cursor_en = 0; cur_a = 0; cur_b = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Output stays 0 for the two refill cycles.
        @(posedge clk); #1; chk("post_rst_c1", pix_a, 0);
        @(posedge clk); #1; chk("post_rst_c2", pix_a, 0);
        fs();
        show(10, 10);   chk("zero_active", pix_a, 0);
        show(700, 10);  chk("outside", pix_a, 7);
        chk("outside_tile", tile_a, 0);

        // Shadow write is invisible until the swap.
        wr(5, 5, 2, 0);
        show(200, 300); chk("no_swap", pix_a, 0);
        fs();
        show(200, 300); chk("swap_pix", pix_a, 2);
        chk("swap_tile", tile_a, 5);

        // Write coinciding with frame_start lands one swap later.
        wr(5, 5, 1, 1);
        show(200, 300); chk("same_cycle_old", pix_a, 2);
        fs();
        show(200, 300); chk("same_cycle_new", pix_a, 1);

        // Borders.
        wr(1, 1, 6, 0); fs();
        show(160, 100); chk("border_160", pix_a, 4);
        show(159, 100); chk("border_159", pix_a, 4);
        show(0, 239);   chk("border_y239", pix_a, 4);
        show(0, 240);   chk("border_y240", pix_a, 4);
        show(161, 100); chk("tile1_inner", pix_a, 6);
        chk("tile1_idx", tile_a, 1);

        // 3x3 instance: remainder column, ignored address, tile 8.
        show(639, 10);  chk("b_remainder", pix_b, 4);
        wr(0, 9, 7, 0);
        wr(0, 8, 5, 0);
        fs();
        show(500, 400); chk("b_tile8_pix", pix_b, 5);
        chk("b_tile8_idx", tile_b, 8);

        // Cursor blink from a clean counter.
        do_reset();
        wr(0, 0, 3, 0);
        cursor_en = 1'b1; cur_a = 3'd0; cur_b = 4'd0;
        for (int k = 1; k <= 60; k++) begin
            fs();
            show(10, 10);
            chk("cursor_a", pix_a, ((k / 30) % 2 != 0) ? 4 : 3);
            chk("cursor_b", pix_b, ((k / 30) % 2 != 0) ? 4 : 3);
            chk("blink_lit", ph_a, (k / 30) % 2);
        end

        // Randomised traffic with a mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(1) == 0) begin
                pos_x = 10'($urandom_range(799));
                pos_y = 9'($urandom_range(511));
            end else begin
                t = int'($urandom_range(4)) * 160 + int'($urandom_range(4)) - 2;
                pos_x = 10'((t < 0) ? 0 : t);
                t = int'($urandom_range(2)) * 160 + int'($urandom_range(4)) - 2;
                pos_y = 9'((t < 0) ? 0 : t);
            end
            wr_en       = ($urandom_range(3) == 0);
            wr_addr_a   = 3'($urandom);
            wr_addr_b   = 4'($urandom);
            wr_data     = 3'($urandom);
            frame_start = ($urandom_range(15) == 0);
            if ($urandom_range(63) == 0) cursor_en = ~cursor_en;
            if ($urandom_range(31) == 0) begin
                cur_a = 3'($urandom);
                cur_b = 4'($urandom_range(8));
            end
            if (i == 1500) begin
                rst = 1'b1;
                #1;
                chk("mid_rst_pix_a", pix_a, 0);
                chk("mid_rst_pix_b", pix_b, 0);
                chk("mid_rst_phase", ph_b, 0);
            end
            if (i == 1503) rst = 1'b0;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
